sincos_arbiter: RTL and testbench

Round-robin scheduler that shares one `sincos_linear` core among `N_REQ` independent requesters. It accepts phase requests over valid/ready handshakes and drives the core's `phase_i`/`mode_cos`/`valid_i`. Each issued operation is tagged, and every core result is routed back with the originating requester ID. It sits directly in front of the core, in the same clock domain, and owns all core-side ports.

---
 rtl/sincos_pkg.sv | 23 ++
 rtl/sincos_tag_fifo.sv | 60 ++++++
 rtl/sincos_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sincos_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// sincos_pkg: shared widths, tag type and FSM states for the sincos_arbiter slice.
`default_nettype none

package sincos_pkg;

  localparam int PHASE_W          = 32;
  localparam int OUTPUT_WIDTH_MAX = 48;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W         = 3;

  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic                cos;
  } sincos_tag_t;

  typedef enum logic [0:0] {
    ST_ISSUE    = 1'b0,
    ST_QUAD_COS = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sincos_tag_fifo.sv
// sincos_tag_fifo: in-flight tag FIFO (power-of-2 depth) with occupancy count and async reset.
`default_nettype none

module sincos_tag_fifo
  import sincos_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  sincos_tag_t            push_tag,
  input  logic                   pop,
  output sincos_tag_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  sincos_tag_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin front end sharing one sincos_linear core, with tagged in-order returns.
// Optional quadrature (sine then cosine per request) enabled by defining SINCOS_ARB_QUADRATURE_EN.
`default_nettype none

module sincos_arbiter
  import sincos_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int OUTPUT_WIDTH = 32,
  parameter int TAG_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*PHASE_W-1:0]   req_phase_i,
  input  logic [N_REQ-1:0]           req_cos_i,
`ifdef SINCOS_ARB_QUADRATURE_EN
  input  logic [N_REQ-1:0]           req_quad_i,
`endif
  output logic                       core_valid_o,
  output logic [PHASE_W-1:0]         core_phase_o,
  output logic                       core_mode_cos_o,
  input  logic                       core_valid_i,
  input  logic [OUTPUT_WIDTH-1:0]    core_result_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic                       rsp_cos_o,
  output logic [OUTPUT_WIDTH-1:0]    rsp_result_o,
  output logic                       err_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  arb_state_t         state;
  arb_state_t         state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic [PHASE_W-1:0] grant_phase;
  logic               grant_cos;
  logic               room_ok;
  logic               can_accept;
  logic               transfer;

  logic               push;
  logic               pop;
  sincos_tag_t        push_tag;
  sincos_tag_t        head_tag;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic               issue;
  logic [PHASE_W-1:0] issue_phase;
  logic               issue_cos;
  logic               unused_tag_bits;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int              idx_int;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx_int     = 0;
    idx         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_int = (int'(rr_ptr) + i) % N_REQ;
      idx     = ID_W'(idx_int);
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign grant_phase = req_phase_i[int'(grant_id)*PHASE_W +: PHASE_W];
  assign grant_cos   = req_cos_i[grant_id];

`ifdef SINCOS_ARB_QUADRATURE_EN
  logic               grant_quad;
  logic [PHASE_W-1:0] quad_phase;
  logic [ID_W-1:0]    quad_id;

  assign grant_quad = req_quad_i[grant_id];
  // A quadrature request commits two tags, so it needs two free slots up front.
  assign room_ok    = grant_quad ? (fifo_count <= CNT_W'(TAG_DEPTH - 2)) : !fifo_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quad_phase <= '0;
      quad_id    <= '0;
    end else if (transfer && grant_quad) begin
      quad_phase <= grant_phase;
      quad_id    <= grant_id;
    end
  end
`else
  assign room_ok = !fifo_full;
`endif

  // Ready is held low while reset is asserted so nothing appears accepted.
  assign can_accept = resetn && (state == ST_ISSUE) && room_ok;
  assign transfer   = grant_found && can_accept;

  always_comb begin
    req_ready_o = '0;
    if (transfer) req_ready_o[grant_id] = 1'b1;
  end

  always_comb begin
    state_next  = state;
    push        = 1'b0;
    push_tag    = '0;
    issue       = 1'b0;
    issue_phase = grant_phase;
    issue_cos   = grant_cos;
    case (state)
      ST_ISSUE: begin
        if (transfer) begin
          issue        = 1'b1;
          push         = 1'b1;
          push_tag.id  = TAG_ID_W'(grant_id);
          push_tag.cos = grant_cos;
`ifdef SINCOS_ARB_QUADRATURE_EN
          if (grant_quad) begin
            issue_cos    = 1'b0;
            push_tag.cos = 1'b0;
            state_next   = ST_QUAD_COS;
          end
`endif
        end
      end
      ST_QUAD_COS: begin
`ifdef SINCOS_ARB_QUADRATURE_EN
        issue        = 1'b1;
        push         = 1'b1;
        issue_phase  = quad_phase;
        issue_cos    = 1'b1;
        push_tag.id  = TAG_ID_W'(quad_id);
        push_tag.cos = 1'b1;
`endif
        state_next   = ST_ISSUE;
      end
      default: state_next = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_ISSUE;
      rr_ptr          <= '0;
      core_valid_o    <= 1'b0;
      core_phase_o    <= '0;
      core_mode_cos_o <= 1'b0;
    end else begin
      state        <= state_next;
      core_valid_o <= issue;
      if (transfer) begin
        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (issue) begin
        core_phase_o    <= issue_phase;
        core_mode_cos_o <= issue_cos;
      end
    end
  end

  sincos_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A result with no tag outstanding is flagged and dropped without popping.
  assign pop             = core_valid_i && !fifo_empty;
  assign unused_tag_bits = ^head_tag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_cos_o    <= 1'b0;
      rsp_result_o <= '0;
      err_o        <= 1'b0;
    end else begin
      rsp_valid_o <= pop;
      if (pop) begin
        rsp_id_o     <= head_tag.id[ID_W-1:0];
        rsp_cos_o    <= head_tag.cos;
        rsp_result_o <= core_result_i;
      end
      if (core_valid_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sincos_arbiter.sv
// tb_sincos_arbiter: mock-core bench with a queue-based reference model and directed scenarios.
`default_nettype none
`timescale 1ns/1ps

module tb_sincos_arbiter;
  import sincos_pkg::*;

  localparam int N     = 4;
  localparam int OW    = 32;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;
`ifdef SINCOS_ARB_QUADRATURE_EN
  localparam logic [N-1:0] QUAD_MASK = '1;
`else
  localparam logic [N-1:0] QUAD_MASK = '0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_phase = '0;
  logic [N-1:0]    req_cos = '0;
  logic [N-1:0]    req_quad = '0;
  logic            core_valid;
  logic [31:0]     core_phase;
  logic            core_cos;
  logic            core_valid_i;
  logic [OW-1:0]   core_result_i;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_cos;
  logic [OW-1:0]   rsp_result;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 5;
  bit inject   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sincos_arbiter #(.N_REQ(N), .OUTPUT_WIDTH(OW), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_phase_i(req_phase), .req_cos_i(req_cos),
`ifdef SINCOS_ARB_QUADRATURE_EN
    .req_quad_i(req_quad),
`endif
    .core_valid_o(core_valid), .core_phase_o(core_phase), .core_mode_cos_o(core_cos),
    .core_valid_i(core_valid_i), .core_result_i(core_result_i),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_cos_o(rsp_cos),
    .rsp_result_o(rsp_result), .err_o(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] mock(input logic [31:0] ph, input logic c);
    return OW'(ph + (c ? 32'h0000_1000 : 32'h0000_0001));
  endfunction

  // Mock core: fixed latency, in order, cleared by the shared reset.
  typedef struct { int due; logic [OW-1:0] res; } pend_t;
  pend_t pipe[$];

  initial begin
    bit fire;
    core_valid_i  = 1'b0;
    core_result_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        pipe.delete();
        core_valid_i = 1'b0;
      end else begin
        fire = 0;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
          fire          = 1;
          core_result_i = pipe[0].res;
          void'(pipe.pop_front());
        end
        core_valid_i = fire | inject;
        if (core_valid) pipe.push_back('{due: cyc + lat, res: mock(core_phase, core_cos)});
      end
    end
  end

  typedef struct { int id; logic cos; logic [OW-1:0] res; int cyc; } rsp_t;
  rsp_t rsp_log[$];

  always @(negedge clk) begin
    if (resetn && rsp_valid) rsp_log.push_back('{id: int'(rsp_id), cos: rsp_cos, res: rsp_result, cyc: cyc});
  end

  // Reference model: outstanding-operation queue plus round-robin pointer.
  typedef struct { int id; logic cos; logic [31:0] phase; } mtag_t;
  mtag_t tq[$];
  int             m_rr = 0;
  bit             m_qpend = 0;
  int             m_qid = 0;
  logic [31:0]    m_qphase = '0;
  logic           e_cv = 0, e_ccos = 0, e_rv = 0, e_rcos = 0, e_err = 0;
  logic [31:0]    e_cph = '0;
  logic [IDW-1:0] e_rid = '0;
  logic [OW-1:0]  e_rres = '0;

  always @(negedge clk) begin : model_p
    logic [N-1:0] e_ready;
    logic [N-1:0] qv;
    logic [31:0]  ph;
    logic         c;
    int           g, k;
    bit           found;
    mtag_t        t;
    if (!resetn) begin
      tq.delete();
      m_rr = 0; m_qpend = 0;
      e_cv = 0; e_ccos = 0; e_cph = '0;
      e_rv = 0; e_rid = '0; e_rcos = 0; e_rres = '0; e_err = 0;
      check("rst_ready", req_ready, '0);
    end
    check("core_valid", core_valid, e_cv);
    check("core_phase", core_phase, e_cph);
    check("core_cos", core_cos, e_ccos);
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_id", rsp_id, e_rid);
    check("rsp_cos", rsp_cos, e_rcos);
    check("rsp_result", rsp_result, e_rres);
    check("err", err, e_err);
    if (resetn) begin
      qv = req_quad & QUAD_MASK;
      e_ready = '0; found = 0; g = 0;
      if (!m_qpend) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (!found && req_valid[k]) begin found = 1; g = k; end
        end
        if (found && (qv[g] ? (tq.size() <= DEPTH - 2) : (tq.size() < DEPTH))) e_ready[g] = 1'b1;
      end
      check("req_ready", req_ready, e_ready);
      e_rv = 0;
      if (core_valid_i) begin
        if (tq.size() == 0) e_err = 1;
        else begin
          t = tq.pop_front();
          e_rv = 1; e_rid = IDW'(t.id); e_rcos = t.cos; e_rres = mock(t.phase, t.cos);
        end
      end
      e_cv = 0;
      if (m_qpend) begin
        tq.push_back('{id: m_qid, cos: 1'b1, phase: m_qphase});
        e_cv = 1; e_cph = m_qphase; e_ccos = 1; m_qpend = 0;
      end else if (|e_ready) begin
        ph = req_phase[g*32 +: 32];
        c  = qv[g] ? 1'b0 : req_cos[g];
        tq.push_back('{id: g, cos: c, phase: ph});
        e_cv = 1; e_cph = ph; e_ccos = c; m_rr = (g + 1) % N;
        if (qv[g]) begin m_qpend = 1; m_qid = g; m_qphase = ph; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_log(input int n, input int max, input string name);
    for (int i = 0; i < max && rsp_log.size() < n; i++) @(negedge clk);
    check(name, rsp_log.size(), n);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int gr[16];
  int acc[16];
  int n, guard, t0;

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Four requesters held valid: strict rotation, responses back-to-back.
    for (int k = 0; k < N; k++) req_phase[k*32 +: 32] = 32'(k + 1) << 28;
    req_cos = 4'b1010;
    rsp_log.delete();
    step(); req_valid = 4'hF; n = 0; guard = 0;
    while (n < 8 && guard < 40) begin
      @(negedge clk); guard++;
      if (|req_ready) begin gr[n] = oh_idx(req_ready); n++; end
      step();
      if (n == 8) req_valid = '0;
    end
    check("rr_transfers", n, 8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_grant%0d", i), gr[i], i % 4);
    wait_log(8, 30, "rr_rsp_count");
    if (rsp_log.size() == 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("rr_rsp_id%0d", i), rsp_log[i].id, i % 4);
      check("rr_rsp_cos3", rsp_log[3].cos, 1'b1);
      check("rr_rsp_span", rsp_log[7].cyc - rsp_log[0].cyc, 7);
    end

    // Single sine request from requester 2, core latency 5.
    rsp_log.delete();
    step(); req_valid = 4'b0100; req_phase[64 +: 32] = 32'h4000_0000; req_cos = '0;
    @(negedge clk); check("single_accept", req_ready, 4'b0100); t0 = cyc;
    step(); req_valid = '0;
    @(negedge clk);
    check("single_core_valid", core_valid, 1'b1);
    check("single_core_phase", core_phase, 32'h4000_0000);
    check("single_core_cos", core_cos, 1'b0);
    wait_log(1, 20, "single_rsp_count");
    if (rsp_log.size() == 1) begin
      check("single_latency", rsp_log[0].cyc - t0, 7);
      check("single_id", rsp_log[0].id, 2);
      check("single_cos", rsp_log[0].cos, 1'b0);
      check("single_result", rsp_log[0].res, 32'h4000_0001);
    end

    // Core latency TAG_DEPTH+2: eight outstanding tags stall the requester.
    repeat (4) step();
    lat = DEPTH + 2;
    rsp_log.delete();
    step(); req_valid = 4'b0001; req_phase[0 +: 32] = 32'h0000_0100; n = 0; guard = 0;
    while (n < 12 && guard < 80) begin
      @(negedge clk); guard++;
      if (req_ready[0]) begin acc[n] = cyc; n++; end
      step();
      req_phase[0 +: 32] = 32'h0000_0100 + 32'(n);
      if (n == 12) req_valid = '0;
    end
    check("full_transfers", n, 12);
    check("full_burst", acc[7] - acc[0], 7);
    check("full_stall_gap", acc[8] - acc[7], 5);
    wait_log(12, 60, "full_rsp_count");
    if (rsp_log.size() == 12) begin
      for (int i = 0; i < 12; i++)
        check($sformatf("full_rsp%0d", i), rsp_log[i].res, 32'h0000_0101 + 32'(i));
    end

    // Core result with nothing outstanding.
    repeat (4) step();
    lat = 5;
    rsp_log.delete();
    @(negedge clk); inject = 1;
    @(negedge clk); inject = 0;
    @(negedge clk); check("err_set", err, 1'b1); check("err_no_rsp", rsp_valid, 1'b0);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1'b1);
    check("err_rsp_log", rsp_log.size(), 0);

    // Reset with three operations in flight.
    step(); req_valid = 4'b0110; n = 0; guard = 0;
    while (n < 3 && guard < 20) begin
      @(negedge clk); guard++;
      if (|req_ready) n++;
      step();
      if (n == 3) req_valid = '0;
    end
    check("rst_inflight", n, 3);
    resetn = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    check("rst_err", err, 1'b0);
    check("rst_core_valid", core_valid, 1'b0);
    check("rst_ready_low", req_ready, 4'b0000);
    step(); step(); req_valid = '0; resetn = 1'b1;
    rsp_log.delete();
    repeat (12) @(negedge clk);
    check("rst_no_stale_rsp", rsp_log.size(), 0);
    step(); req_valid = 4'hF;
    @(negedge clk); check("rst_first_grant", req_ready, 4'b0001);
    step(); req_valid = '0;
    repeat (10) step();

`ifdef SINCOS_ARB_QUADRATURE_EN
    // Requester 1 quadrature: sine then cosine, others blocked one cycle.
    rsp_log.delete();
    step(); req_valid = 4'b0111; req_quad = 4'b0010; req_phase[32 +: 32] = 32'h2000_0000;
    @(negedge clk); check("quad_accept", req_ready, 4'b0010);
    step(); req_valid = 4'b0101; req_quad = '0;
    @(negedge clk);
    check("quad_blocked", req_ready, 4'b0000);
    check("quad_sin_valid", core_valid, 1'b1);
    check("quad_sin_cos", core_cos, 1'b0);
    check("quad_sin_phase", core_phase, 32'h2000_0000);
    step();
    @(negedge clk);
    check("quad_next_grant", req_ready, 4'b0100);
    check("quad_cos_valid", core_valid, 1'b1);
    check("quad_cos_cos", core_cos, 1'b1);
    check("quad_cos_phase", core_phase, 32'h2000_0000);
    step(); req_valid = '0;
    wait_log(3, 20, "quad_rsp_count");
    if (rsp_log.size() == 3) begin
      check("quad_rsp0_id", rsp_log[0].id, 1);
      check("quad_rsp0_res", rsp_log[0].res, 32'h2000_0001);
      check("quad_rsp1_id", rsp_log[1].id, 1);
      check("quad_rsp1_cos", rsp_log[1].cos, 1'b1);
      check("quad_rsp1_res", rsp_log[1].res, 32'h2000_1000);
      check("quad_rsp_gap", rsp_log[1].cyc - rsp_log[0].cyc, 1);
    end
    repeat (4) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
